// File: rtl/maske_range_pipe.sv
// ---------------------------------------------------------------------------
// maske_range_pipe
//
// Streaming mask generator. Each request carries a low index, a high index,
// a mode and an inclusive flag. The module turns them into a W-bit mask and
// returns it one cycle later through a registered output stage backed by a
// single skid entry. Indices at or above W are clamped to W-1, and the
// clamp is reported alongside the mask.
//
// Modes (in_mode_i):
//   00 RIGHT  : bits below lo (incl: up to and including lo)
//   01 LEFT   : bits above lo (incl: from lo upward)
//   10 RANGE  : lo..hi inclusive; wraps around when lo > hi
//   11 NRANGE : complement of RANGE
//
// Optional feature macro: MASKE_POPCNT_EN
//   When defined, the popcount of each mask travels with it and is
//   presented on out_cnt_o. When undefined, the port and logic are absent.
//
// Ports:
//   clk          clock
//   rst          synchronous reset, active-high
//   in_vld_i     request valid
//   in_rdy_o     request ready (registered, 0 while in reset)
//   in_lo_i      low / primary index
//   in_hi_i      high index (range modes only)
//   in_mode_i    mode select
//   in_incl_i    inclusive select (RIGHT/LEFT only)
//   out_vld_o    mask valid
//   out_rdy_i    mask ready
//   out_mask_o   generated mask
//   out_clamp_o  an index >= W was clamped
//   out_cnt_o    popcount of out_mask_o (MASKE_POPCNT_EN only)
// ---------------------------------------------------------------------------
module maske_range_pipe #(
    parameter  int W  = 32,
    localparam int LW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld_i,
    output logic          in_rdy_o,
    input  logic [LW-1:0] in_lo_i,
    input  logic [LW-1:0] in_hi_i,
    input  logic [1:0]    in_mode_i,
    input  logic          in_incl_i,
    output logic          out_vld_o,
    input  logic          out_rdy_i,
    output logic [W-1:0]  out_mask_o,
    output logic          out_clamp_o
`ifdef MASKE_POPCNT_EN
    ,
    output logic [LW:0]   out_cnt_o
`endif
);

    localparam logic [LW:0]   W_EXT   = (LW+1)'(W);
    localparam logic [LW-1:0] MAX_IDX = LW'(W - 1);
    localparam logic [W-1:0]  ONES    = {W{1'b1}};

    // ---------------------------------------------------------------
    // Index clamping
    // ---------------------------------------------------------------
    logic          lo_ovf, hi_ovf;
    logic [LW-1:0] lo_c, hi_c;
    logic          clamp_c;

    assign lo_ovf  = {1'b0, in_lo_i} >= W_EXT;
    assign hi_ovf  = {1'b0, in_hi_i} >= W_EXT;
    assign lo_c    = lo_ovf ? MAX_IDX : in_lo_i;
    assign hi_c    = hi_ovf ? MAX_IDX : in_hi_i;
    // hi only matters (and so only counts as clamped) in the range modes
    assign clamp_c = lo_ovf | (hi_ovf & in_mode_i[1]);

    // ---------------------------------------------------------------
    // Mask construction from thermometer codes
    //   ge_lo : bits i >= lo
    //   gt_lo : bits i >  lo
    //   le_hi : bits i <= hi
    // ---------------------------------------------------------------
    logic [W-1:0] ge_lo, gt_lo, le_hi, rng, mask_c;

    assign ge_lo = ONES << lo_c;
    assign gt_lo = ge_lo << 1;
    assign le_hi = ~((ONES << hi_c) << 1);
    // lo > hi selects the wrapped region (top part OR bottom part)
    assign rng   = (lo_c <= hi_c) ? (ge_lo & le_hi) : (ge_lo | le_hi);

    always_comb begin
        mask_c = '0;
        case (in_mode_i)
            2'b00:   mask_c = in_incl_i ? ~gt_lo : ~ge_lo;
            2'b01:   mask_c = in_incl_i ? ge_lo : gt_lo;
            2'b10:   mask_c = rng;
            default: mask_c = ~rng;
        endcase
    end

`ifdef MASKE_POPCNT_EN
    // Running-sum chain; psum[W] is the total number of set bits
    logic [LW:0] psum [W+1];
    assign psum[0] = '0;
    for (genvar gi = 0; gi < W; gi++) begin : g_popcnt
        assign psum[gi+1] = psum[gi] + (LW+1)'(mask_c[gi]);
    end
`endif

    // ---------------------------------------------------------------
    // Output register + one skid entry
    // ---------------------------------------------------------------
    logic         in_rdy_reg;
    logic         out_vld_reg;
    logic [W-1:0] out_mask_reg;
    logic         out_clamp_reg;
    logic         skid_vld_reg;
    logic [W-1:0] skid_mask_reg;
    logic         skid_clamp_reg;
`ifdef MASKE_POPCNT_EN
    logic [LW:0]  out_cnt_reg;
    logic [LW:0]  skid_cnt_reg;
`endif

    logic accept, consume;
    assign accept  = in_vld_i & in_rdy_reg;
    assign consume = out_vld_reg & out_rdy_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            in_rdy_reg     <= 1'b0;
            out_vld_reg    <= 1'b0;
            out_mask_reg   <= '0;
            out_clamp_reg  <= 1'b0;
            skid_vld_reg   <= 1'b0;
            skid_mask_reg  <= '0;
            skid_clamp_reg <= 1'b0;
`ifdef MASKE_POPCNT_EN
            out_cnt_reg    <= '0;
            skid_cnt_reg   <= '0;
`endif
        end else begin
            in_rdy_reg <= 1'b1;
            if (skid_vld_reg) begin
                // in_rdy is low here, so no accept can coincide
                if (consume) begin
                    out_mask_reg  <= skid_mask_reg;
                    out_clamp_reg <= skid_clamp_reg;
`ifdef MASKE_POPCNT_EN
                    out_cnt_reg   <= skid_cnt_reg;
`endif
                    skid_vld_reg  <= 1'b0;
                end else begin
                    in_rdy_reg    <= 1'b0;
                end
            end else if (accept) begin
                if (!out_vld_reg || out_rdy_i) begin
                    // slot empty or draining this cycle: load output directly
                    out_vld_reg   <= 1'b1;
                    out_mask_reg  <= mask_c;
                    out_clamp_reg <= clamp_c;
`ifdef MASKE_POPCNT_EN
                    out_cnt_reg   <= psum[W];
`endif
                end else begin
                    skid_vld_reg   <= 1'b1;
                    skid_mask_reg  <= mask_c;
                    skid_clamp_reg <= clamp_c;
`ifdef MASKE_POPCNT_EN
                    skid_cnt_reg   <= psum[W];
`endif
                    in_rdy_reg     <= 1'b0;
                end
            end else if (consume) begin
                out_vld_reg <= 1'b0;
            end
        end
    end

    assign in_rdy_o    = in_rdy_reg;
    assign out_vld_o   = out_vld_reg;
    assign out_mask_o  = out_mask_reg;
    assign out_clamp_o = out_clamp_reg;
`ifdef MASKE_POPCNT_EN
    assign out_cnt_o   = out_cnt_reg;
`endif

endmodule

// File: tb/tb_maske_range_pipe.sv
// ---------------------------------------------------------------------------
// tb_maske_range_pipe
//
// Four instances (W = 2, 8, 12, 32) share clock, reset, handshake and
// request fields; each takes the low bits of the shared 5-bit indices that
// fit its index width. Directed scenarios check the W=8 / W=12 instances;
// the random scenario checks all four against a behavioural model.
// ---------------------------------------------------------------------------
module tb_maske_range_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst   = 1'b1;
    logic       vld   = 1'b0;
    logic       ordy  = 1'b0;
    logic       incl  = 1'b0;
    logic [1:0] mode  = 2'b00;
    logic [4:0] lo    = '0;
    logic [4:0] hi    = '0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [1:0]  m2;
    logic [7:0]  m8;
    logic [11:0] m12;
    logic [31:0] m32;
    logic ir2, ir8, ir12, ir32;
    logic ov2, ov8, ov12, ov32;
    logic oc2, oc8, oc12, oc32;
`ifdef MASKE_POPCNT_EN
    logic [1:0] c2;
    logic [3:0] c8;
    logic [4:0] c12;
    logic [5:0] c32;
`endif

    maske_range_pipe #(.W(2)) u_w2 (
        .clk(clk), .rst(rst), .in_vld_i(vld), .in_rdy_o(ir2),
        .in_lo_i(lo[0:0]), .in_hi_i(hi[0:0]), .in_mode_i(mode), .in_incl_i(incl),
        .out_vld_o(ov2), .out_rdy_i(ordy), .out_mask_o(m2), .out_clamp_o(oc2)
`ifdef MASKE_POPCNT_EN
        , .out_cnt_o(c2)
`endif
    );
    maske_range_pipe #(.W(8)) u_w8 (
        .clk(clk), .rst(rst), .in_vld_i(vld), .in_rdy_o(ir8),
        .in_lo_i(lo[2:0]), .in_hi_i(hi[2:0]), .in_mode_i(mode), .in_incl_i(incl),
        .out_vld_o(ov8), .out_rdy_i(ordy), .out_mask_o(m8), .out_clamp_o(oc8)
`ifdef MASKE_POPCNT_EN
        , .out_cnt_o(c8)
`endif
    );
    maske_range_pipe #(.W(12)) u_w12 (
        .clk(clk), .rst(rst), .in_vld_i(vld), .in_rdy_o(ir12),
        .in_lo_i(lo[3:0]), .in_hi_i(hi[3:0]), .in_mode_i(mode), .in_incl_i(incl),
        .out_vld_o(ov12), .out_rdy_i(ordy), .out_mask_o(m12), .out_clamp_o(oc12)
`ifdef MASKE_POPCNT_EN
        , .out_cnt_o(c12)
`endif
    );
    maske_range_pipe #(.W(32)) u_w32 (
        .clk(clk), .rst(rst), .in_vld_i(vld), .in_rdy_o(ir32),
        .in_lo_i(lo), .in_hi_i(hi), .in_mode_i(mode), .in_incl_i(incl),
        .out_vld_o(ov32), .out_rdy_i(ordy), .out_mask_o(m32), .out_clamp_o(oc32)
`ifdef MASKE_POPCNT_EN
        , .out_cnt_o(c32)
`endif
    );

    // Uniform views, index 0..3 = W 2, 8, 12, 32
    logic [31:0] om   [4];
    logic        ov   [4];
    logic        oc   [4];
    logic        ir   [4];
    logic [5:0]  ocnt [4];

    always_comb begin
        om[0] = 32'(m2);  om[1] = 32'(m8);  om[2] = 32'(m12); om[3] = m32;
        ov[0] = ov2;      ov[1] = ov8;      ov[2] = ov12;     ov[3] = ov32;
        oc[0] = oc2;      oc[1] = oc8;      oc[2] = oc12;     oc[3] = oc32;
        ir[0] = ir2;      ir[1] = ir8;      ir[2] = ir12;     ir[3] = ir32;
        ocnt[0] = '0; ocnt[1] = '0; ocnt[2] = '0; ocnt[3] = '0;
`ifdef MASKE_POPCNT_EN
        ocnt[0] = 6'(c2); ocnt[1] = 6'(c8); ocnt[2] = 6'(c12); ocnt[3] = c32;
`endif
    end

    // ---------------- reference model ----------------
    function automatic int wof(int k);
        case (k)
            0: return 2;
            1: return 8;
            2: return 12;
            default: return 32;
        endcase
    endfunction

    function automatic int lwof(int k);
        case (k)
            0: return 1;
            1: return 3;
            2: return 4;
            default: return 5;
        endcase
    endfunction

    function automatic int idx_of(logic [4:0] v, int k);
        return int'(v) % (1 << lwof(k));
    endfunction

    function automatic logic [31:0] ref_mask(int w, int l, int h, logic [1:0] md, logic inc);
        logic [31:0] r;
        int lc, hc;
        logic in_rng;
        r  = '0;
        lc = (l > w - 1) ? w - 1 : l;
        hc = (h > w - 1) ? w - 1 : h;
        for (int i = 0; i < w; i++) begin
            if (lc <= hc) in_rng = (i >= lc) && (i <= hc);
            else          in_rng = (i >= lc) || (i <= hc);
            case (md)
                2'd0:    r[i] = inc ? (i <= lc) : (i < lc);
                2'd1:    r[i] = inc ? (i >= lc) : (i > lc);
                2'd2:    r[i] = in_rng;
                default: r[i] = !in_rng;
            endcase
        end
        return r;
    endfunction

    function automatic logic ref_clamp(int w, int l, int h, logic [1:0] md);
        return (l >= w) || ((h >= w) && md[1]);
    endfunction

    // Drive one request and hold it until accepted; returns at accept edge + 1
    task automatic send(input logic [1:0] md, input logic inc, input logic [4:0] l, input logic [4:0] h);
        logic got;
        int   c;
        mode = md; incl = inc; lo = l; hi = h; vld = 1'b1;
        c = 0;
        got = 1'b0;
        do begin
            @(negedge clk);
            got = ir[1];
            @(posedge clk);
            #1;
            c++;
        end while (!got && c < 20);
        vld = 1'b0;
        if (!got) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: in_rdy_o stayed 0 for %0d cycles, required 1", c);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; vld = 1'b0; ordy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (ov[k] !== 1'b0 || om[k] !== 32'h0 || oc[k] !== 1'b0 || ocnt[k] !== 6'h0) begin
                n_bad++;
                $display("FAIL reset_out[W=%0d]: vld=%b mask=%h clamp=%b cnt=%0d, required 0/0/0/0",
                         wof(k), ov[k], om[k], oc[k], ocnt[k]);
            end
        end
        n_cmp++;
        if (ir[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_rdy_low: in_rdy_o=%b, required 0", ir[1]);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (ir[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_rdy_rise: in_rdy_o=%b, required 1", ir[1]);
        end
    endtask

    task automatic test_right();
        ordy = 1'b1;
        send(2'd0, 1'b0, 5'd3, 5'd0);
        n_cmp++;
        if (ov[1] !== 1'b1 || om[1] !== 32'h07 || oc[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL right_excl_lo3: vld=%b mask=%h clamp=%b, required 1/07/0", ov[1], om[1], oc[1]);
        end
    endtask

    task automatic test_wrap();
        ordy = 1'b1;
        send(2'd2, 1'b0, 5'd6, 5'd1);
        n_cmp++;
        if (ov[1] !== 1'b1 || om[1] !== 32'hC3) begin
            n_bad++;
            $display("FAIL range_wrap: vld=%b mask=%h, required 1/c3", ov[1], om[1]);
        end
        send(2'd3, 1'b1, 5'd6, 5'd1);
        n_cmp++;
        if (ov[1] !== 1'b1 || om[1] !== 32'h3C) begin
            n_bad++;
            $display("FAIL nrange_wrap: vld=%b mask=%h, required 1/3c", ov[1], om[1]);
        end
`ifdef MASKE_POPCNT_EN
        n_cmp++;
        if (ocnt[1] !== 6'd4) begin
            n_bad++;
            $display("FAIL nrange_cnt: cnt=%0d, required 4", ocnt[1]);
        end
`endif
    endtask

    task automatic test_clamp();
        ordy = 1'b1;
        send(2'd1, 1'b1, 5'd14, 5'd0);
        n_cmp++;
        if (om[2] !== 32'h800 || oc[2] !== 1'b1) begin
            n_bad++;
            $display("FAIL clamp_w12_left: mask=%h clamp=%b, required 800/1", om[2], oc[2]);
        end
        // same indices, wider instance: no clamp, bits 14..31
        n_cmp++;
        if (om[3] !== 32'hFFFF_C000 || oc[3] !== 1'b0) begin
            n_bad++;
            $display("FAIL left_w32_lo14: mask=%h clamp=%b, required ffffc000/0", om[3], oc[3]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp8 [4];
        int idx, got;
        logic acc, con;
        exp8[0] = 32'h01; exp8[1] = 32'h03; exp8[2] = 32'h07; exp8[3] = 32'h0F;
        ordy = 1'b1;
        @(posedge clk);
        #1;
        ordy = 1'b0;
        idx = 0; got = 0;
        mode = 2'd0; incl = 1'b1; lo = 5'd0; hi = 5'd0; vld = 1'b1;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            @(negedge clk);
            acc = vld && ir[1];
            con = ov[1] && ordy;
            if (con) begin
                n_cmp++;
                if (om[1] !== exp8[got]) begin
                    n_bad++;
                    $display("FAIL b2b_order[%0d]: mask=%h, required %h", got, om[1], exp8[got]);
                end
                got++;
            end
            if (cyc == 6) begin
                n_cmp++;
                if (ir[1] !== 1'b0 || ov[1] !== 1'b1 || om[1] !== 32'h01 || idx != 2) begin
                    n_bad++;
                    $display("FAIL b2b_stall: rdy=%b vld=%b mask=%h accepted=%0d, required 0/1/01/2",
                             ir[1], ov[1], om[1], idx);
                end
            end
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                if (idx < 4) lo = 5'(idx);
                else         vld = 1'b0;
            end
            if (cyc == 6) ordy = 1'b1;
        end
        vld = 1'b0;
        n_cmp++;
        if (got != 4) begin
            n_bad++;
            $display("FAIL b2b_count: drained=%0d, required 4", got);
        end
    endtask

    task automatic test_mid_reset();
        ordy = 1'b0;
        send(2'd0, 1'b1, 5'd4, 5'd0);
        send(2'd0, 1'b1, 5'd5, 5'd0);
        n_cmp++;
        if (ov[1] !== 1'b1 || ir[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_full: vld=%b rdy=%b, required 1/0", ov[1], ir[1]);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (ov[1] !== 1'b0 || om[1] !== 32'h0 || ir[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_clear: vld=%b mask=%h rdy=%b, required 0/0/0", ov[1], om[1], ir[1]);
        end
        rst = 1'b0;
        ordy = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (ir[1] !== 1'b1 || ov[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_after: rdy=%b vld=%b, required 1/0", ir[1], ov[1]);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (ov[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_no_ghost: vld=%b, required 0", ov[1]);
        end
    endtask

    typedef struct packed {
        logic [3:0][31:0] m;
        logic [3:0]       c;
    } exp_t;

    task automatic test_random();
        exp_t q[$];
        exp_t e;
        logic acc;
        int   pct;
        vld = 1'b0;
        ordy = 1'b1;
        pct = 100;
        for (int cyc = 0; cyc < 1200; cyc++) begin
            @(negedge clk);
            if (ov[1] && ordy) begin
                if (q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL rand_extra_output: mask=%h with empty scoreboard, required none", om[1]);
                end else begin
                    e = q.pop_front();
                    for (int k = 0; k < 4; k++) begin
                        n_cmp++;
                        if (ov[k] !== 1'b1 || om[k] !== e.m[k] || oc[k] !== e.c[k]) begin
                            n_bad++;
                            $display("FAIL rand_out[W=%0d]: vld=%b mask=%h clamp=%b, required 1/%h/%b",
                                     wof(k), ov[k], om[k], oc[k], e.m[k], e.c[k]);
                        end
`ifdef MASKE_POPCNT_EN
                        n_cmp++;
                        if (ocnt[k] !== 6'($countones(e.m[k]))) begin
                            n_bad++;
                            $display("FAIL rand_cnt[W=%0d]: cnt=%0d, required %0d",
                                     wof(k), ocnt[k], $countones(e.m[k]));
                        end
`endif
                    end
                end
            end
            acc = vld && ir[1];
            if (acc) begin
                for (int k = 0; k < 4; k++) begin
                    e.m[k] = ref_mask(wof(k), idx_of(lo, k), idx_of(hi, k), mode, incl);
                    e.c[k] = ref_clamp(wof(k), idx_of(lo, k), idx_of(hi, k), mode);
                end
                q.push_back(e);
            end
            @(posedge clk);
            #1;
            if (cyc % 150 == 0) pct = $urandom_range(10, 100);
            if (!vld || acc) begin
                vld  = ($urandom_range(0, 3) != 0);
                mode = 2'($urandom);
                incl = 1'($urandom);
                lo   = 5'($urandom);
                hi   = 5'($urandom);
            end
            ordy = ($urandom_range(1, 100) <= pct);
        end
        // drain: finish any pending request, then empty the pipe
        ordy = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (ov[1] && ordy) begin
                if (q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL drain_extra_output: mask=%h, required none", om[1]);
                end else begin
                    e = q.pop_front();
                    for (int k = 0; k < 4; k++) begin
                        n_cmp++;
                        if (om[k] !== e.m[k] || oc[k] !== e.c[k]) begin
                            n_bad++;
                            $display("FAIL drain_out[W=%0d]: mask=%h clamp=%b, required %h/%b",
                                     wof(k), om[k], oc[k], e.m[k], e.c[k]);
                        end
                    end
                end
            end
            acc = vld && ir[1];
            if (acc) begin
                for (int k = 0; k < 4; k++) begin
                    e.m[k] = ref_mask(wof(k), idx_of(lo, k), idx_of(hi, k), mode, incl);
                    e.c[k] = ref_clamp(wof(k), idx_of(lo, k), idx_of(hi, k), mode);
                end
                q.push_back(e);
            end
            @(posedge clk);
            #1;
            if (acc) vld = 1'b0;
        end
        n_cmp++;
        if (q.size() != 0 || ov[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL rand_drain: pending=%0d vld=%b, required 0/0", q.size(), ov[1]);
        end
    endtask

    initial begin
        test_reset();
        test_right();
        test_wrap();
        test_clamp();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
